// File: rtl/lfsr_rr_arbiter.sv
// Round-robin arbiter handing out draws from one shared 8-bit LFSR.
// Optional runtime seed load port: define LFSR_SEED_LOAD_EN.
module lfsr_rr_arbiter #(
  parameter int          N_REQ = 4,
  parameter logic [7:0]  SEED  = 8'h01,
  localparam int         ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             rnd_valid,
  output logic [7:0]       rnd_data,
  output logic [ID_W-1:0]  rnd_id
`ifdef LFSR_SEED_LOAD_EN
  ,
  input  logic             seed_we,
  input  logic [7:0]       seed_data
`endif
);

  localparam logic [7:0] SEED_FIX =
    (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [N_REQ-1:0] ONE =
    {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    SERVE
  } state_t;

  state_t          state;
  logic [7:0]      lfsr;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] win;
  logic            found;
  logic            seed_ld;
  logic [7:0]      seed_val;
  logic [7:0]      lfsr_nx;

  function automatic logic [7:0] step(
    input logic [7:0] s
  );
    if (s == 8'h00) return 8'h01;
    return {^s[3:0], s[7:1]};
  endfunction

`ifdef LFSR_SEED_LOAD_EN
  assign seed_ld  = seed_we;
  assign seed_val = (seed_data == 8'h00)
                  ? 8'h01 : seed_data;
`else
  assign seed_ld  = 1'b0;
  assign seed_val = SEED_FIX;
`endif

  assign lfsr_nx = step(lfsr);

  // Search upward from the slot after the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int j;
      j = (int'(last) + 1 + i) % N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = ID_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED_FIX;
      last      <= ID_W'(N_REQ - 1);
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= 8'h00;
      rnd_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (seed_ld) begin
            lfsr      <= seed_val;
            gnt       <= '0;
            rnd_valid <= 1'b0;
          end else if (found) begin
            gnt       <= ONE << win;
            rnd_id    <= win;
            rnd_valid <= 1'b1;
            rnd_data  <= lfsr_nx;
            lfsr      <= lfsr_nx;
            last      <= win;
            state     <= SERVE;
          end else begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
          end
        end
        SERVE: begin
          gnt       <= '0;
          rnd_valid <= 1'b0;
          state     <= IDLE;
          if (seed_ld) lfsr <= seed_val;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rr_arbiter.sv
// Scoreboard bench for lfsr_rr_arbiter (N_REQ = 4, SEED = 8'h01).
// Seed-load scenarios are built only when LFSR_SEED_LOAD_EN is defined.
module tb_lfsr_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic       rnd_valid;
  logic [7:0] rnd_data;
  logic [1:0] rnd_id;
`ifdef LFSR_SEED_LOAD_EN
  logic       seed_we = 1'b0;
  logic [7:0] seed_data = '0;
`endif

  lfsr_rr_arbiter #(
    .N_REQ(4),
    .SEED (8'h01)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .rnd_valid(rnd_valid),
    .rnd_data (rnd_data),
    .rnd_id   (rnd_id)
`ifdef LFSR_SEED_LOAD_EN
    ,
    .seed_we  (seed_we),
    .seed_data(seed_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every presented grant must match the head of the queue.
  always @(negedge clk) begin
    if (rnd_valid) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_grant gnt=%b id=%0d data=%h",
                 gnt, rnd_id, rnd_data);
      end else begin
        e = q.pop_front();
        if (gnt !== e.gnt || rnd_id !== e.id ||
            rnd_data !== e.data ||
            (e.gap != 0 && cyc - last_cyc != e.gap))
          $display({"FAIL grant got gnt=%b id=%0d data=%h gap=%0d",
                    " want gnt=%b id=%0d data=%h gap=%0d"},
                   gnt, rnd_id, rnd_data, cyc - last_cyc,
                   e.gnt, e.id, e.data, e.gap);
        else
          passed++;
      end
      last_cyc = cyc;
    end
  end

  task automatic push(input logic [1:0] id,
                      input logic [7:0] data,
                      input int gap);
    exp_t e;
    e.gnt  = 4'b0001 << id;
    e.id   = id;
    e.data = data;
    e.gap  = gap;
    q.push_back(e);
  endtask

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s got %h want %h", name, act, exp);
    else
      passed++;
  endtask

  // Returns #1 after the negedge at which the last expected grant popped.
  task automatic drain(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (q.size() != 0 && n < budget);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout left=%0d want 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_gnt",   {4'b0, gnt},       8'h00);
    chk("rst_valid", {7'b0, rnd_valid}, 8'h00);
    chk("rst_data",  rnd_data,          8'h00);
    chk("rst_id",    {6'b0, rnd_id},    8'h00);

    // Single requester: one grant every 2 cycles, LFSR sequence.
    push(0, 8'h80, 0);
    push(0, 8'h40, 2);
    push(0, 8'h20, 2);
    push(0, 8'h10, 2);
    push(0, 8'h08, 2);
    push(0, 8'h84, 2);
    push(0, 8'hC2, 2);
    req = 4'b0001;
    drain(40);
    req = '0;

    // All requesting: strict rotation, wrap from 3 to 0.
    do_reset();
    push(0, 8'h80, 0);
    push(1, 8'h40, 2);
    push(2, 8'h20, 2);
    push(3, 8'h10, 2);
    push(0, 8'h08, 2);
    req = 4'b1111;
    drain(30);
    req = '0;

    // Sparse requests, then req[3] drops during its SERVE cycle.
    do_reset();
    push(1, 8'h80, 0);
    push(3, 8'h40, 2);
    push(1, 8'h20, 2);
    push(3, 8'h10, 2);
    req = 4'b1010;
    drain(30);
    req = 4'b0010;
    push(1, 8'h08, 2);
    push(1, 8'h84, 2);
    drain(20);
    req = '0;

    // Reset during SERVE drops the grant and restores the seed.
    do_reset();
    push(0, 8'h80, 0);
    req = 4'b0001;
    drain(10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("srv_rst_gnt",   {4'b0, gnt},       8'h00);
    chk("srv_rst_valid", {7'b0, rnd_valid}, 8'h00);
    chk("srv_rst_data",  rnd_data,          8'h00);
    push(0, 8'h80, 0);
    drain(10);
    req = '0;

`ifdef LFSR_SEED_LOAD_EN
    // Zero seed becomes 8'h01 and blocks arbitration for that cycle.
    do_reset();
    seed_we   = 1'b1;
    seed_data = 8'h00;
    req       = 4'b0001;
    @(posedge clk);
    #1;
    seed_we = 1'b0;
    chk("seed_no_gnt", {7'b0, rnd_valid}, 8'h00);
    push(0, 8'h80, 0);
    drain(10);
    // Seed load while in SERVE, then two more draws.
    seed_we   = 1'b1;
    seed_data = 8'h08;
    req       = '0;
    @(posedge clk);
    #1;
    seed_we = 1'b0;
    push(0, 8'h84, 0);
    push(0, 8'hC2, 2);
    req = 4'b0001;
    drain(20);
    req = '0;
`endif

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
